// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan driver.
package seg7_pkg;

  // Converter FSM states
  typedef enum logic [0:0] {
    StIdle,
    StConvert
  } state_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SegDigit0 = 7'b1000000;
  localparam logic [6:0] SegDigit1 = 7'b1111001;
  localparam logic [6:0] SegDigit2 = 7'b0100100;
  localparam logic [6:0] SegDigit3 = 7'b0110000;
  localparam logic [6:0] SegDigit4 = 7'b0011001;
  localparam logic [6:0] SegDigit5 = 7'b0010010;
  localparam logic [6:0] SegDigit6 = 7'b0000010;
  localparam logic [6:0] SegDigit7 = 7'b1111000;
  localparam logic [6:0] SegDigit8 = 7'b0000000;
  localparam logic [6:0] SegDigit9 = 7'b0010000;
  localparam logic [6:0] SegBlank  = 7'b1111111;

  // Width of a BCD accumulator holding the given number of digits
  function automatic int unsigned bcd_width(input int unsigned digits);
    return 4 * digits;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment pattern.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup; codes above 9 are unreachable and render dark
  always_comb begin
    seg = SegBlank;
    case (nibble)
      4'd0:    seg = SegDigit0;
      4'd1:    seg = SegDigit1;
      4'd2:    seg = SegDigit2;
      4'd3:    seg = SegDigit3;
      4'd4:    seg = SegDigit4;
      4'd5:    seg = SegDigit5;
      4'd6:    seg = SegDigit6;
      4'd7:    seg = SegDigit7;
      4'd8:    seg = SegDigit8;
      4'd9:    seg = SegDigit9;
      default: seg = SegBlank;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Latches a binary value, converts it to BCD with shift-add-3 (one bit per
// clock) and multiplexes the digits onto a common-anode display with
// leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WIDTH-1:0]  value,
  output logic              busy,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              dp
);

  localparam int unsigned BcdW = bcd_width(DIGITS);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RefW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [BcdW-1:0]     bcd_q, bcd_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BcdW-1:0]     disp_q, disp_d;
  logic [RefW-1:0]     ref_q, ref_d;
  logic [IdxW-1:0]     idx_q, idx_d;

  logic [BcdW-1:0]       bcd_adj;
  logic [BcdW+WIDTH-1:0] shifted;
  logic [3:0]            cur_nibble;
  logic [6:0]            cur_seg;
  logic [BcdW-1:0]       upper_nibbles;
  logic                  blank;

  // State registers; reset aborts any conversion and clears the display
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ref_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
    end
  end

  // Converter next state: add-3 correction then a one-bit shift per cycle
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj, bin_q} << 1;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = StConvert;
        end
      end
      StConvert: begin
        {bcd_d, bin_d} = shifted;
        cnt_d          = cnt_q + CntW'(1);
        // Last shift: publish the whole result in one step
        if (cnt_q == CntW'(WIDTH - 1)) begin
          disp_d  = shifted[WIDTH +: BcdW];
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Free-running refresh divider and digit index
  always_comb begin
    ref_d = ref_q + RefW'(1);
    idx_d = idx_q;
    if (ref_q == RefW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
    end
  end

  // Active digit selection and leading-zero blanking
  always_comb begin
    cur_nibble    = disp_q[4*idx_q +: 4];
    upper_nibbles = disp_q >> (4 * idx_q);
    blank         = (idx_q != '0) && (upper_nibbles == '0);
    an            = ~(DIGITS'(1) << idx_q);
    seg           = cur_seg;
    if (blank) begin
      an  = '1;
      seg = SegBlank;
    end
  end

  bcd_to_seg7 u_dec (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  assign busy = (state_q == StConvert);
  assign dp   = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised bench for seg7_scan_driver checked against an arithmetic model
// of the displayed number, conversion latency and scan position.
module tb_seg7_scan_driver;

  localparam int unsigned Width  = 8;
  localparam int unsigned Digits = 4;
  localparam int unsigned Div    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load = 1'b0;
  logic [Width-1:0]  value = '0;
  logic              busy;
  logic [6:0]        seg;
  logic [Digits-1:0] an;
  logic              dp;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int m_disp      = 0;
  int m_pending   = 0;
  int m_busy_left = 0;
  int m_scan      = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  seg7_scan_driver #(
    .WIDTH       (Width),
    .DIGITS      (Digits),
    .REFRESH_DIV (Div)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .value (value),
    .busy  (busy),
    .seg   (seg),
    .an    (an),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  task automatic model_reset();
    m_disp      = 0;
    m_pending   = 0;
    m_busy_left = 0;
    m_scan      = 0;
  endtask

  // Advance the model by one rising edge using the inputs seen at that edge
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) m_disp = m_pending;
      end else if (load) begin
        m_pending   = int'(value);
        m_busy_left = Width;
      end
      m_scan = (m_scan + 1) % (Digits * Div);
    end
  endtask

  task automatic compare_all(input string ctx);
    int         idx;
    int         digit;
    bit         blank;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    idx     = m_scan / Div;
    digit   = (m_disp / pow10(idx)) % 10;
    blank   = (idx > 0) && (m_disp < pow10(idx));
    exp_seg = blank ? 7'b1111111 : seg_tab[digit];
    exp_an  = blank ? 4'b1111 : ~(4'b0001 << idx);
    check_eq({ctx, ".busy"}, 32'(busy), 32'(m_busy_left > 0));
    check_eq({ctx, ".an"}, 32'(an), 32'(exp_an));
    check_eq({ctx, ".seg"}, 32'(seg), 32'(exp_seg));
    check_eq({ctx, ".dp"}, 32'(dp), 32'd1);
  endtask

  task automatic cycle(input string ctx);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all(ctx);
  endtask

  task automatic run(input string ctx, input int n);
    for (int i = 0; i < n; i++) cycle(ctx);
  endtask

  task automatic pulse_load(input string ctx, input int v);
    load  = 1'b1;
    value = Width'(v);
    cycle(ctx);
    load  = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all("reset");
    rst = 1'b0;

    // Idle: only the units digit lit across more than one full scan
    run("idle", 20);

    pulse_load("v255", 255);
    run("v255", 30);

    // Loads during the conversion must be dropped
    pulse_load("v7", 7);
    load  = 1'b1;
    value = Width'(99);
    run("v7_busy", 8);
    load  = 1'b0;
    run("v7", 20);
    check_eq("v7_disp_model", 32'(m_disp), 32'd7);

    pulse_load("v100", 100);
    run("v100", 24);

    // Reset in the middle of a conversion
    pulse_load("v200", 200);
    run("v200", 3);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all("rst_async");
    run("rst_hold", 2);
    rst = 1'b0;
    run("post_rst", 3);
    pulse_load("v42", 42);
    run("v42", 24);

    pulse_load("v0", 0);
    run("v0_scan", 40);

    // Random loads, including many that arrive while busy
    for (int i = 0; i < 400; i++) begin
      load  = ($urandom % 4) == 0;
      value = Width'($urandom % 256);
      cycle("rand");
    end
    load = 1'b0;
    run("drain", 20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
